boot_loader: RTL

- Upstream feeder of the 5-stage processor core.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory, then checks a trailing XOR checksum.
- Holds the core in reset (drives the core's nrst input) until the image has loaded and verified.

---
 rtl/boot_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Boot loader: assembles a little-endian word image from a byte stream into
// instruction memory, verifies an XOR checksum, then releases core reset.
module boot_loader #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              reload,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_nrst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {HDR0, HDR1, LOAD, CSUM, RUN, ERR} state_t;

  state_t      state, state_nxt;
  logic [15:0] n_words;
  logic [15:0] n_hdr;
  logic [1:0]  lane;
  logic [7:0]  csum;
  logic [23:0] word_sr;
  logic        xfer;
  logic        last_done;

  always_comb begin
    n_hdr     = {in_data, n_words[7:0]};
    last_done = (32'(words_loaded) == 32'(n_words));
    in_ready  = 1'b0;
    case (state)
      HDR0, HDR1, CSUM: in_ready = !reload;
      // Hold off the checksum byte while the final word's write is in flight.
      LOAD:             in_ready = !reload && !last_done;
      default:          in_ready = 1'b0;
    endcase
    xfer = in_valid && in_ready;

    state_nxt = state;
    case (state)
      HDR0: if (xfer) state_nxt = HDR1;
      HDR1: if (xfer) begin
        if (32'(n_hdr) > IMEM_DEPTH) state_nxt = ERR;
        else if (n_hdr == 16'd0)     state_nxt = CSUM;
        else                         state_nxt = LOAD;
      end
      LOAD: if (last_done) state_nxt = CSUM;
      CSUM: if (xfer) state_nxt = (in_data == csum) ? RUN : ERR;
      default: state_nxt = state;
    endcase
    if (reload) state_nxt = HDR0;

    busy = (state == HDR0) || (state == HDR1) || (state == LOAD) || (state == CSUM);
    done = (state == RUN);
    err  = (state == ERR);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= HDR0;
      core_nrst    <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      n_words      <= '0;
      lane         <= '0;
      csum         <= '0;
      word_sr      <= '0;
    end else begin
      state     <= state_nxt;
      core_nrst <= (state_nxt == RUN);
      imem_we   <= 1'b0;
      if (reload) begin
        words_loaded <= '0;
        n_words      <= '0;
        lane         <= '0;
        csum         <= '0;
        word_sr      <= '0;
      end else if (xfer) begin
        case (state)
          HDR0: n_words[7:0]  <= in_data;
          HDR1: n_words[15:8] <= in_data;
          LOAD: begin
            csum <= csum ^ in_data;
            lane <= lane + 2'd1;
            // Bytes shift in from the top so lane 0 ends up least significant.
            if (lane == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= {in_data, word_sr};
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
            end else begin
              word_sr <= {in_data, word_sr[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
